// File: rtl/lsu.sv
// Load/store unit sitting between a RISC-V core and a word-wide data memory.
// The memory has no byte enables, so sub-word stores use read-modify-write
// (read the containing word, then write it back with the target lane replaced).
// Loads take one stall cycle; word stores complete in the cycle they are issued.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned requests are rejected and flagged on core_misalign_o
//   undefined -> low address bits are truncated to the access alignment
module lsu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] RMW_WRITE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic [15:0] wd_q, wd_d;

  logic        isWord;
  logic        isHalf;
  logic [1:0]  alignedOff;
  logic        trap;

  logic [31:0] rdComb;
  logic        stallComb;
  logic        misalignComb;
  logic        memReqComb;
  logic        memWeComb;
  logic [31:0] memAddrComb;
  logic [31:0] memWdComb;

  // Pick the addressed byte/half/word out of a memory word and extend it.
  function automatic logic [31:0] loadExtract(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  size);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    if (size[1])
      res = word;
    else if (size[0])
      res = size[2] ? {16'h0000, h} : {{16{h[15]}}, h};
    else
      res = size[2] ? {24'h000000, b} : {{24{b[7]}}, b};
    return res;
  endfunction

  // Replace the target byte or half of the old word with the store data.
  function automatic logic [31:0] storeMerge(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic        half,
                                             input logic [15:0] wd);
    logic [31:0] res;
    res = word;
    if (half) begin
      if (off[1])
        res[31:16] = wd;
      else
        res[15:0] = wd;
    end else begin
      res[8*off +: 8] = wd[7:0];
    end
    return res;
  endfunction

  // Width decode and alignment handling of the incoming request.
  always_comb begin
    isWord = core_size_i[1];
    isHalf = ~core_size_i[1] & core_size_i[0];
    if (isWord)
      alignedOff = 2'b00;
    else if (isHalf)
      alignedOff = {core_addr_i[1], 1'b0};
    else
      alignedOff = core_addr_i[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    trap = core_req_i & ((isHalf & core_addr_i[0]) |
                         (isWord & (core_addr_i[1:0] != 2'b00)));
`else
    trap = 1'b0;
`endif
  end

  // Next-state and output decode; outputs are forced to zero while reset is low.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    off_d        = off_q;
    size_d       = size_q;
    wd_d         = wd_q;
    rdComb       = 32'h0;
    stallComb    = 1'b0;
    misalignComb = 1'b0;
    memReqComb   = 1'b0;
    memWeComb    = 1'b0;
    memAddrComb  = 32'h0;
    memWdComb    = 32'h0;

    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (trap) begin
            misalignComb = 1'b1;
          end else if (core_we_i && isWord) begin
            memReqComb  = 1'b1;
            memWeComb   = 1'b1;
            memAddrComb = {core_addr_i[31:2], 2'b00};
            memWdComb   = core_wd_i;
          end else begin
            memReqComb  = 1'b1;
            stallComb   = 1'b1;
            memAddrComb = {core_addr_i[31:2], 2'b00};
            addr_d      = core_addr_i[31:2];
            off_d       = alignedOff;
            size_d      = core_size_i;
            wd_d        = core_wd_i[15:0];
            state_d     = core_we_i ? RMW_WRITE : LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        rdComb      = loadExtract(mem_rd_i, off_q, size_q);
        memAddrComb = {addr_q, 2'b00};
        state_d     = IDLE;
      end
      RMW_WRITE: begin
        memReqComb  = 1'b1;
        memWeComb   = 1'b1;
        memAddrComb = {addr_q, 2'b00};
        memWdComb   = storeMerge(mem_rd_i, off_q, size_q[0], wd_q);
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!rst_ni) begin
      rdComb       = 32'h0;
      stallComb    = 1'b0;
      misalignComb = 1'b0;
      memReqComb   = 1'b0;
      memWeComb    = 1'b0;
      memAddrComb  = 32'h0;
      memWdComb    = 32'h0;
    end
  end

  assign core_rd_o       = rdComb;
  assign core_stall_o    = stallComb;
  assign core_misalign_o = misalignComb;
  assign mem_req_o       = memReqComb;
  assign mem_we_o        = memWeComb;
  assign mem_addr_o      = memAddrComb;
  assign mem_wd_o        = memWdComb;

  // State and latched request registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= 30'h0;
      off_q   <= 2'b00;
      size_q  <= 3'b000;
      wd_q    <= 16'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small word-addressed memory model.
// Build with +define+LSU_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coreReq;
  logic        coreWe;
  logic [2:0]  coreSize;
  logic [31:0] coreAddr;
  logic [31:0] coreWd;
  logic [31:0] coreRd;
  logic        coreStall;
  logic        coreMisalign;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWd;
  logic [31:0] memRd;

  logic [31:0] mem [0:1023];
  logic        preload;
  int          writeCount;
  int          total;
  int          bad;
  int          savedWrites;

  lsu dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .core_req_i     (coreReq),
    .core_we_i      (coreWe),
    .core_size_i    (coreSize),
    .core_addr_i    (coreAddr),
    .core_wd_i      (coreWd),
    .core_rd_o      (coreRd),
    .core_stall_o   (coreStall),
    .core_misalign_o(coreMisalign),
    .mem_req_o      (memReq),
    .mem_we_o       (memWe),
    .mem_addr_o     (memAddr),
    .mem_wd_o       (memWd),
    .mem_rd_i       (memRd)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Memory: read data appears the cycle after a read request; writes land on the edge.
  always @(posedge clk) begin
    if (preload) begin
      mem[10'h040] <= 32'h8899AABB;
      writeCount   <= 0;
      memRd        <= 32'h0;
    end else if (memReq) begin
      if (memWe) begin
        mem[memAddr[11:2]] <= memWd;
        writeCount         <= writeCount + 1;
      end else begin
        memRd <= mem[memAddr[11:2]];
      end
    end
  end

  task automatic applyStimulus(input logic req, input logic we, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wd);
    coreReq  = req;
    coreWe   = we;
    coreSize = size;
    coreAddr = addr;
    coreWd   = wd;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    preload = 1'b1;
    rst_n   = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    checkOutput("reset memReq", {31'b0, memReq}, 32'h0);
    checkOutput("reset stall", {31'b0, coreStall}, 32'h0);
    checkOutput("reset rd", coreRd, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    coreReq = 1'b0;
    rst_n   = 1'b1;
    nextCycle();

    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("idle memReq", {31'b0, memReq}, 32'h0);
    checkOutput("idle stall", {31'b0, coreStall}, 32'h0);
    nextCycle();

    // LB 0x101
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h101, 32'h0);
    checkOutput("LB req", {30'b0, memReq, memWe}, 32'h2);
    checkOutput("LB stall", {31'b0, coreStall}, 32'h1);
    checkOutput("LB addr", memAddr, 32'h100);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("LB data", coreRd, 32'hFFFFFFAA);
    checkOutput("LB stall2", {30'b0, coreStall, memReq}, 32'h0);
    nextCycle();

    // LBU 0x101
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h101, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("LBU data", coreRd, 32'h000000AA);
    nextCycle();

    // LH 0x102
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("LH data", coreRd, 32'hFFFF8899);
    nextCycle();

    // LHU 0x102
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("LHU data", coreRd, 32'h00008899);
    nextCycle();

    // LW 0x100
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("LW data", coreRd, 32'h8899AABB);
    nextCycle();
    checkOutput("idle rd", coreRd, 32'h0);

    // SB 0x11 at 0x103; core request dropped during the write phase
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h103, 32'h00000011);
    checkOutput("SB read req", {30'b0, memReq, memWe}, 32'h2);
    checkOutput("SB read stall", {31'b0, coreStall}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("SB write req", {30'b0, memReq, memWe}, 32'h3);
    checkOutput("SB write data", memWd, 32'h1199AABB);
    checkOutput("SB write addr", memAddr, 32'h100);
    checkOutput("SB write stall", {31'b0, coreStall}, 32'h0);
    nextCycle();
    checkOutput("SB mem", mem[10'h040], 32'h1199AABB);

    // SW 0xDEADBEEF at 0x200
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h200, 32'hDEADBEEF);
    checkOutput("SW req", {30'b0, memReq, memWe}, 32'h3);
    checkOutput("SW data", memWd, 32'hDEADBEEF);
    checkOutput("SW stall", {31'b0, coreStall}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("SW after", {30'b0, memReq, coreStall}, 32'h0);
    checkOutput("SW mem", mem[10'h080], 32'hDEADBEEF);
    nextCycle();

    // LW 0x102: trapped or truncated to 0x100
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("MIS flag", {31'b0, coreMisalign}, 32'h1);
    checkOutput("MIS memReq", {31'b0, memReq}, 32'h0);
    checkOutput("MIS stall", {31'b0, coreStall}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("MIS after", {30'b0, coreMisalign, coreStall}, 32'h0);
`else
    checkOutput("MIS flag", {31'b0, coreMisalign}, 32'h0);
    checkOutput("MIS memReq", {31'b0, memReq}, 32'h1);
    checkOutput("MIS addr", memAddr, 32'h100);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("MIS data", coreRd, 32'h1199AABB);
`endif
    nextCycle();

    // SH 0x5566 at 0x202, reset pulsed during RMW_WRITE
    applyStimulus(1'b1, 1'b1, 3'b001, 32'h202, 32'h00005566);
    checkOutput("SH read stall", {31'b0, coreStall}, 32'h1);
    nextCycle();
    savedWrites = writeCount;
    checkOutput("SH in write", {31'b0, memWe}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("RST memReq", {30'b0, memReq, memWe}, 32'h0);
    checkOutput("RST memWd", memWd, 32'h0);
    checkOutput("RST stall", {31'b0, coreStall}, 32'h0);
    coreReq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("RST no write", writeCount, savedWrites);
    checkOutput("RST mem", mem[10'h080], 32'hDEADBEEF);

    // Next request after reset: LHU 0x202
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h202, 32'h0);
    checkOutput("POST req", {30'b0, memReq, coreStall}, 32'h3);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("POST data", coreRd, 32'h0000DEAD);
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
